// File: rtl/game_pkg.sv
// game_pkg: shared types and width helpers for the maze-game flow controller.
//   state_t       - encoding of the game-flow state, also driven on the
//                   'state' output of game_status_fsm.
//   width_for()   - bits needed to hold the values 0..max_value (min 1).
//   index_width() - bits needed to index 'count' items 0..count-1 (min 1).
package game_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PLAYING    = 3'd1,
    RESPAWN    = 3'd2,
    LEVEL_DONE = 3'd3,
    GAME_OVER  = 3'd4,
    WON        = 3'd5
  } state_t;

  function automatic int unsigned width_for(input int unsigned max_value);
    if (max_value <= 32'd1) begin
      return 32'd1;
    end else begin
      return $clog2(max_value + 32'd1);
    end
  endfunction

  function automatic int unsigned index_width(input int unsigned count);
    if (count <= 32'd2) begin
      return 32'd1;
    end else begin
      return $clog2(count);
    end
  endfunction

endpackage

// File: rtl/game_status_fsm_rise_edge.sv
// rise_edge: registered rising-edge detector for a level-sensitive button.
//   clk   in  system clock
//   reset in  synchronous, active-high
//   din   in  level-sensitive button input
//   rise  out one-cycle pulse, registered, one clock after din goes high
// Holding din high produces exactly one pulse.
module rise_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic din_q_r;
  logic rise_r;

  // Delay the input by one clock and register the rising-edge decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      din_q_r <= 1'b0;
      rise_r  <= 1'b0;
    end else begin
      din_q_r <= din;
      rise_r  <= din & ~din_q_r;
    end
  end

  assign rise = rise_r;

endmodule

// File: rtl/game_status_fsm.sv
// game_status_fsm: game-flow controller for the maze game.
// Tracks lives, level and a per-level countdown and arbitrates start,
// hazard, goal and timeout events (priority in that order).
//   clk, reset    in  clock, synchronous active-high reset
//   start_button  in  level-sensitive start/restart (edge-detected inside)
//   hazard        in  per-channel collision flags
//   hazard_en     in  per-channel enable mask
//   goalblk       in  player on goal block
//   tick          in  single-cycle countdown strobe
//   state         out current state (game_pkg::state_t)
//   lives         out lives remaining
//   level         out current level, 0-based
//   time_left     out countdown value
//   gamestart     out one-cycle pulse on game (re)start
//   level_start   out one-cycle pulse whenever PLAYING is entered
//   freeze        out high whenever state is not PLAYING
//   gameover      out high in GAME_OVER and WON
//   complete      out high in WON only
// All outputs are registered.
module game_status_fsm
  import game_pkg::*;
#(
  parameter int NUM_LIVES    = 3,
  parameter int NUM_LEVELS   = 4,
  parameter int NUM_HAZARDS  = 4,
  parameter int TIME_LIMIT   = 60,
  parameter int PAUSE_CYCLES = 8,
  localparam int LIVES_W = width_for(NUM_LIVES),
  localparam int LEVEL_W = index_width(NUM_LEVELS),
  localparam int TIME_W  = width_for(TIME_LIMIT)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_button,
  input  logic [NUM_HAZARDS-1:0] hazard,
  input  logic [NUM_HAZARDS-1:0] hazard_en,
  input  logic                   goalblk,
  input  logic                   tick,
  output logic [2:0]             state,
  output logic [LIVES_W-1:0]     lives,
  output logic [LEVEL_W-1:0]     level,
  output logic [TIME_W-1:0]      time_left,
  output logic                   gamestart,
  output logic                   level_start,
  output logic                   freeze,
  output logic                   gameover,
  output logic                   complete
);

  localparam int PAUSE_W = index_width(PAUSE_CYCLES);

  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(NUM_LIVES);
  localparam logic [LIVES_W-1:0] LIVES_ONE  = LIVES_W'(1);
  localparam logic [LIVES_W-1:0] LIVES_ZERO = LIVES_W'(0);
  localparam logic [LEVEL_W-1:0] LEVEL_ZERO = LEVEL_W'(0);
  localparam logic [LEVEL_W-1:0] LEVEL_ONE  = LEVEL_W'(1);
  localparam logic [LEVEL_W-1:0] LEVEL_LAST = LEVEL_W'(NUM_LEVELS - 1);
  localparam logic [TIME_W-1:0]  TIME_INIT  = TIME_W'(TIME_LIMIT);
  localparam logic [TIME_W-1:0]  TIME_ONE   = TIME_W'(1);
  localparam logic [TIME_W-1:0]  TIME_ZERO  = TIME_W'(0);
  localparam logic [PAUSE_W-1:0] PAUSE_ZERO = PAUSE_W'(0);
  localparam logic [PAUSE_W-1:0] PAUSE_ONE  = PAUSE_W'(1);
  localparam logic [PAUSE_W-1:0] PAUSE_LAST = PAUSE_W'(PAUSE_CYCLES - 1);

  state_t             state_r, state_s;
  logic [LIVES_W-1:0] lives_r, lives_s;
  logic [LEVEL_W-1:0] level_r, level_s;
  logic [TIME_W-1:0]  time_r, time_s;
  logic [PAUSE_W-1:0] pause_r, pause_s;
  logic               gamestart_r, gamestart_s;
  logic               level_start_r, level_start_s;
  logic               freeze_r, gameover_r, complete_r;
  logic               start_rise_s;
  logic               hazard_hit_s;
  logic               timeout_s;

  rise_edge u_start_edge (
    .clk   (clk),
    .reset (reset),
    .din   (start_button),
    .rise  (start_rise_s)
  );

  assign hazard_hit_s = |(hazard & hazard_en);
  assign timeout_s    = tick && (time_r == TIME_ONE);

  // Next-state and counter decode; pause states and absorbing states ignore play inputs.
  always_comb begin
    state_s       = state_r;
    lives_s       = lives_r;
    level_s       = level_r;
    time_s        = time_r;
    pause_s       = pause_r;
    gamestart_s   = 1'b0;
    level_start_s = 1'b0;

    if (start_rise_s) begin
      state_s       = PLAYING;
      lives_s       = LIVES_INIT;
      level_s       = LEVEL_ZERO;
      time_s        = TIME_INIT;
      pause_s       = PAUSE_ZERO;
      gamestart_s   = 1'b1;
      level_start_s = 1'b1;
    end else begin
      case (state_r)
        PLAYING: begin
          // The countdown follows every tick in PLAYING, even when another
          // event wins the cycle, so a goal on the last tick still shows 0.
          if (tick && (time_r != TIME_ZERO)) begin
            time_s = time_r - TIME_ONE;
          end else begin
            time_s = time_r;
          end

          if (hazard_hit_s || (!goalblk && timeout_s)) begin
            pause_s = PAUSE_ZERO;
            if (lives_r <= LIVES_ONE) begin
              lives_s = LIVES_ZERO;
              state_s = GAME_OVER;
            end else begin
              lives_s = lives_r - LIVES_ONE;
              state_s = RESPAWN;
            end
          end else if (goalblk) begin
            pause_s = PAUSE_ZERO;
            if (level_r >= LEVEL_LAST) begin
              state_s = WON;
            end else begin
              level_s = level_r + LEVEL_ONE;
              state_s = LEVEL_DONE;
            end
          end else begin
            state_s = PLAYING;
          end
        end

        RESPAWN, LEVEL_DONE: begin
          if (pause_r >= PAUSE_LAST) begin
            state_s       = PLAYING;
            time_s        = TIME_INIT;
            pause_s       = PAUSE_ZERO;
            level_start_s = 1'b1;
          end else begin
            pause_s = pause_r + PAUSE_ONE;
          end
        end

        IDLE, GAME_OVER, WON: begin
          state_s = state_r;
        end

        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // State, counters and decoded status flags, all registered together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      lives_r       <= LIVES_INIT;
      level_r       <= LEVEL_ZERO;
      time_r        <= TIME_INIT;
      pause_r       <= PAUSE_ZERO;
      gamestart_r   <= 1'b0;
      level_start_r <= 1'b0;
      freeze_r      <= 1'b1;
      gameover_r    <= 1'b0;
      complete_r    <= 1'b0;
    end else begin
      state_r       <= state_s;
      lives_r       <= lives_s;
      level_r       <= level_s;
      time_r        <= time_s;
      pause_r       <= pause_s;
      gamestart_r   <= gamestart_s;
      level_start_r <= level_start_s;
      freeze_r      <= (state_s != PLAYING);
      gameover_r    <= (state_s == GAME_OVER) || (state_s == WON);
      complete_r    <= (state_s == WON);
    end
  end

  assign state       = state_r;
  assign lives       = lives_r;
  assign level       = level_r;
  assign time_left   = time_r;
  assign gamestart   = gamestart_r;
  assign level_start = level_start_r;
  assign freeze      = freeze_r;
  assign gameover    = gameover_r;
  assign complete    = complete_r;

endmodule

// File: doc/game_status_fsm.md
# game_status_fsm

Parametrised game-flow controller for the FPGA maze game. It sits between the collision/goal detection logic and the display/movement logic. It tracks the player's lives, the current level and a per-level countdown. It arbitrates hazard, goal, timeout and start events into a state machine with start, level-change, game-over and win indications.

## Interface
Parameters:
- NUM_LIVES, 3: lives granted at game start; must be ≥1.
- NUM_LEVELS, 4: levels per game; must be ≥1.
- NUM_HAZARDS, 4: width of the hazard input vector, one bit per hazard channel (lava, enemy, ...).
- TIME_LIMIT, 60: countdown reload value in ticks; must be ≥1.
- PAUSE_CYCLES, 8: clocks spent in RESPAWN and LEVEL_DONE; must be ≥1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- start_button  in  1  level-sensitive start/restart request; internally edge-detected.
- hazard  in  NUM_HAZARDS  per-channel collision flags.
- hazard_en  in  NUM_HAZARDS  per-channel enable mask; a hazard counts only when hazard[i] & hazard_en[i].
- goalblk  in  1  player on goal block.
- tick  in  1  single-cycle countdown strobe (e.g. 1 Hz enable).
- state  out  3  current state encoding (game_pkg::state_t).
- lives  out  $clog2(NUM_LIVES+1)  lives remaining.
- level  out  $clog2(NUM_LEVELS) (min 1)  current level, 0-based.
- time_left  out  $clog2(TIME_LIMIT+1)  countdown value.
- gamestart  out  1  one-cycle pulse on game (re)start.
- level_start  out  1  one-cycle pulse whenever PLAYING is entered.
- freeze  out  1  high whenever state ≠ PLAYING; movement logic halts.
- gameover  out  1  high in GAME_OVER and WON.
- complete  out  1  high in WON only.

## Operation
- States are IDLE, PLAYING, RESPAWN, LEVEL_DONE, GAME_OVER and WON.
- start_rise = start_button & ~start_q, where start_q is a registered copy of start_button. Holding the button produces exactly one event.
- Event priority per cycle: reset > start_rise > hazard_hit > goalblk > timeout.
- start_rise in any state:
  - go to PLAYING.
  - lives←NUM_LIVES, level←0, time_left←TIME_LIMIT.
  - pulse gamestart and level_start.
- The following events act in PLAYING only:
  - hazard_hit = |(hazard & hazard_en).
  - timeout = tick && time_left==1. On this tick time_left becomes 0.
  - tick without timeout decrements time_left.
- Death (hazard_hit or timeout):
  - if lives==1: lives←0, go to GAME_OVER.
  - else: lives←lives−1, go to RESPAWN.
- goalblk:
  - if level==NUM_LEVELS−1: go to WON.
  - else: level←level+1, go to LEVEL_DONE.
- RESPAWN and LEVEL_DONE:
  - a pause counter runs PAUSE_CYCLES clocks.
  - on expiry: time_left←TIME_LIMIT, go to PLAYING, pulse level_start.
  - hazard, goal and tick inputs are ignored.
- GAME_OVER, WON and IDLE are absorbing; only start_rise or reset leaves them.
- In non-PLAYING states time_left holds its value; tick is ignored.

## Timing
- All outputs are registered.
- Every transition and every counter update is visible on the clock edge after the input is sampled. Latency is 1 cycle, plus 1 cycle for start_button because of the edge detector.
- Reset values:
  - state=IDLE, lives=NUM_LIVES, level=0, time_left=TIME_LIMIT.
  - gamestart=0, level_start=0, gameover=0, complete=0, freeze=1.
  - start_q=0, pause counter=0.
- freeze, gameover and complete are decoded from the next state and registered together with state, so they change in the same cycle as state.
- The pause is exactly PAUSE_CYCLES clocks: entry at edge N, PLAYING at edge N+PAUSE_CYCLES.
- Reset mid-pause or mid-game overrides everything on the next edge.
- Simultaneous hazard and goal: death wins, and level does not advance.
- Simultaneous tick-timeout and goal: goal wins. time_left still updates to 0 that cycle.
- No counter wraps. lives saturates at 0, level at NUM_LEVELS−1, and time_left at 0.

## Structure
- game_pkg holds:
  - typedef enum logic [2:0] state_t {IDLE, PLAYING, RESPAWN, LEVEL_DONE, GAME_OVER, WON}.
  - shared width helper functions.
- Sub-module: rise_edge (registered rising-edge detector). Reused for start_button and other buttons.
- Single always_ff for state and counters, with an always_comb next-state decode.

## Test plan
- Reset, then pulse start_button for 3 cycles → one gamestart pulse; state=PLAYING, lives=3, level=0, time_left=60, freeze=0.
- hazard=4'b0010, hazard_en=4'b1111 for 1 cycle with 3 lives → lives=2, RESPAWN for 8 clocks, then PLAYING with level_start pulse and time_left=60. Repeat with hazard_en=4'b1101 → no effect.
- Three deaths → lives=0, GAME_OVER, gameover=1, complete=0. Further hazard or goal input → no change.
- goalblk on levels 0–3 → level increments 0→3 via LEVEL_DONE; goal on level 3 → WON with gameover=1, complete=1. Hazard and goal in the same cycle on level 2 → RESPAWN, level stays 2.
- With TIME_LIMIT=3, issue 3 ticks → time_left goes 2, 1, 0, then RESPAWN and lives−1. Tick in the same cycle as goalblk when time_left==1 → LEVEL_DONE.
- Assert reset during RESPAWN → IDLE with all reset values next edge. start_button during WON → PLAYING, level=0, lives=3.
